// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 frame writer.
// Latency: none (package only).
// Backpressure: not applicable.
package lcd_pkg;

   // Top-level sequencing states
   typedef enum logic [3:0] {
      ST_POWERUP,
      ST_INIT,
      ST_IDLE,
      ST_SNAP,
      ST_ADDR0,
      ST_ROW0,
      ST_ADDR1,
      ST_ROW1,
      ST_FINISH
   } state_t;

   // Single-byte transfer phases
   typedef enum logic [1:0] {
      TX_IDLE,
      TX_SETUP,
      TX_EN,
      TX_WAIT
   } tx_state_t;

   // [1] = top row, [0] = bottom row; within a row [15] is column 0
   typedef logic [1:0][15:0][7:0] frame_t;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_ROW0     = 8'h80;
   localparam logic [7:0] CMD_ROW1     = 8'hC0;

   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_MIN   = 8'h20;
   localparam logic [7:0] CHAR_MAX   = 8'h7E;

   // Non-printable bytes are drawn as blanks
   function automatic logic [7:0] sanitise(input logic [7:0] c);
      return ((c < CHAR_MIN) || (c > CHAR_MAX)) ? CHAR_SPACE : c;
   endfunction

   // Controller init commands, in the order they are issued
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return CMD_FUNC_SET;
         2'd1:    return CMD_DISP_ON;
         2'd2:    return CMD_ENTRY;
         default: return CMD_CLEAR;
      endcase
   endfunction

endpackage

// File: rtl/lcd_frame_writer_if.sv
// Host-row inputs, LCD pins and status of the frame writer.
// Latency: none (wiring only).
// Backpressure: none; the LCD bus is write-only and self-timed.
interface lcd_frame_writer_if;
   logic [127:0] top;
   logic [127:0] bottom;
   logic         lcd_en;
   logic         lcd_rs;
   logic         lcd_rw;
   logic [7:0]   lcd_data;
   logic         busy;
   logic         frame_done;

   modport master (
      input  top, bottom,
      output lcd_en, lcd_rs, lcd_rw, lcd_data, busy, frame_done
   );

   modport slave (
      output top, bottom,
      input  lcd_en, lcd_rs, lcd_rw, lcd_data, busy, frame_done
   );
endinterface

// File: rtl/lcd_byte_tx.sv
// Sends one byte on the LCD bus: setup, enable pulse, then settle wait.
// Latency: start to done = SETUP_CYC + EN_CYC + wait cycles (long wait for clear).
// Backpressure: start is only honoured while idle; done pulses one cycle.
module lcd_byte_tx
   import lcd_pkg::*;
#(
   parameter int SETUP_CYC      = 2,
   parameter int EN_CYC         = 5,
   parameter int WAIT_CYC       = 400,
   parameter int CLEAR_WAIT_CYC = 16400
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       start,
   input  logic       rs_in,
   input  logic [7:0] data_in,
   output logic       done,
   output logic       lcd_en,
   output logic       lcd_rs,
   output logic [7:0] lcd_data
);
   localparam int MAX_AB  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
   localparam int MAX_CD  = (WAIT_CYC > CLEAR_WAIT_CYC) ? WAIT_CYC : CLEAR_WAIT_CYC;
   localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW      = $clog2(MAX_CYC) + 1;

   tx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          en_q, en_d;
   logic          rs_q, rs_d;
   logic [7:0]    data_q, data_d;
   logic          done_q, done_d;
   logic [CW-1:0] wait_last;

   // The clear command needs the long settle time, everything else the short one
   always_comb begin
      wait_last = (!rs_q && (data_q == CMD_CLEAR)) ? CW'(CLEAR_WAIT_CYC - 1)
                                                   : CW'(WAIT_CYC - 1);
   end

   // Phase sequencing; rs/data are latched at start and held until the next start
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      rs_d    = rs_q;
      data_d  = data_q;
      done_d  = 1'b0;
      case (state_q)
         TX_IDLE: begin
            if (start) begin
               rs_d    = rs_in;
               data_d  = data_in;
               cnt_d   = '0;
               state_d = TX_SETUP;
            end
         end
         TX_SETUP: begin
            if (cnt_q == CW'(SETUP_CYC - 1)) begin
               cnt_d   = '0;
               en_d    = 1'b1;
               state_d = TX_EN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         TX_EN: begin
            if (cnt_q == CW'(EN_CYC - 1)) begin
               cnt_d   = '0;
               en_d    = 1'b0;
               state_d = TX_WAIT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         TX_WAIT: begin
            if (cnt_q == wait_last) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = TX_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= TX_IDLE;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   assign done     = done_q;
   assign lcd_en   = en_q;
   assign lcd_rs   = rs_q;
   assign lcd_data = data_q;

endmodule

// File: rtl/lcd_frame_writer.sv
// Initialises a 16x2 HD44780 LCD and redraws both rows whenever they change.
// Latency: a frame is 34 byte transfers taken from a snapshot of the rows.
// Backpressure: row changes during a frame are held off until the frame ends.
module lcd_frame_writer
   import lcd_pkg::*;
#(
   parameter int POWERUP_CYC    = 150000,
   parameter int SETUP_CYC      = 2,
   parameter int EN_CYC         = 5,
   parameter int WAIT_CYC       = 400,
   parameter int CLEAR_WAIT_CYC = 16400
) (
   input  logic                clk,
   input  logic                nRst,
   lcd_frame_writer_if.master  bus
);
   localparam int PW = $clog2(POWERUP_CYC) + 1;

   state_t        state_q, state_d;
   logic [PW-1:0] pwr_q, pwr_d;
   logic [1:0]    init_idx_q, init_idx_d;
   logic [3:0]    col_q, col_d;
   frame_t        shadow_q, shadow_d;
   logic          dirty_q, dirty_d;
   logic          pend_q, pend_d;
   logic          start_q, start_d;
   logic          busy_q, busy_d;
   logic          fdone_q, fdone_d;

   frame_t        in_frame;
   logic          tx_rs;
   logic [7:0]    tx_data;
   logic          tx_done;

   assign in_frame = {bus.top, bus.bottom};

   // Byte to send in the current state; stable for the whole transfer
   always_comb begin
      tx_rs   = 1'b0;
      tx_data = 8'h00;
      case (state_q)
         ST_INIT:  tx_data = init_cmd(init_idx_q);
         ST_ADDR0: tx_data = CMD_ROW0;
         ST_ROW0: begin
            tx_rs   = 1'b1;
            tx_data = sanitise(shadow_q[1][4'd15 - col_q]);
         end
         ST_ADDR1: tx_data = CMD_ROW1;
         ST_ROW1: begin
            tx_rs   = 1'b1;
            tx_data = sanitise(shadow_q[0][4'd15 - col_q]);
         end
         default: ;
      endcase
   end

   // Sequencing: each sending state issues one start, then advances on done
   always_comb begin
      state_d    = state_q;
      pwr_d      = pwr_q;
      init_idx_d = init_idx_q;
      col_d      = col_q;
      shadow_d   = shadow_q;
      dirty_d    = dirty_q;
      pend_d     = pend_q;
      start_d    = 1'b0;
      case (state_q)
         ST_POWERUP: begin
            if (pwr_q == PW'(POWERUP_CYC - 1)) begin
               pwr_d   = '0;
               state_d = ST_INIT;
            end else begin
               pwr_d = pwr_q + PW'(1);
            end
         end
         ST_INIT, ST_ADDR0, ST_ROW0, ST_ADDR1, ST_ROW1: begin
            if (!pend_q) begin
               start_d = 1'b1;
               pend_d  = 1'b1;
            end else if (tx_done) begin
               pend_d = 1'b0;
               case (state_q)
                  ST_INIT: begin
                     init_idx_d = init_idx_q + 2'd1;
                     if (init_idx_q == 2'd3) state_d = ST_SNAP;
                  end
                  ST_ADDR0: begin
                     col_d   = 4'd0;
                     state_d = ST_ROW0;
                  end
                  ST_ROW0: begin
                     col_d = col_q + 4'd1;
                     if (col_q == 4'd15) state_d = ST_ADDR1;
                  end
                  ST_ADDR1: begin
                     col_d   = 4'd0;
                     state_d = ST_ROW1;
                  end
                  default: begin
                     col_d = col_q + 4'd1;
                     if (col_q == 4'd15) state_d = ST_FINISH;
                  end
               endcase
            end
         end
         ST_IDLE: begin
            if (dirty_q || (in_frame != shadow_q)) state_d = ST_SNAP;
         end
         ST_SNAP: begin
            shadow_d = in_frame;
            dirty_d  = 1'b0;
            state_d  = ST_ADDR0;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_POWERUP;
      endcase
      busy_d  = (state_d != ST_IDLE);
      fdone_d = (state_d == ST_FINISH);
   end

   // State registers; shadow resets to blanks and is marked dirty for the first draw
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q    <= ST_POWERUP;
         pwr_q      <= '0;
         init_idx_q <= 2'd0;
         col_q      <= 4'd0;
         shadow_q   <= {32{CHAR_SPACE}};
         dirty_q    <= 1'b1;
         pend_q     <= 1'b0;
         start_q    <= 1'b0;
         busy_q     <= 1'b1;
         fdone_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pwr_q      <= pwr_d;
         init_idx_q <= init_idx_d;
         col_q      <= col_d;
         shadow_q   <= shadow_d;
         dirty_q    <= dirty_d;
         pend_q     <= pend_d;
         start_q    <= start_d;
         busy_q     <= busy_d;
         fdone_q    <= fdone_d;
      end
   end

   lcd_byte_tx #(
      .SETUP_CYC      (SETUP_CYC),
      .EN_CYC         (EN_CYC),
      .WAIT_CYC       (WAIT_CYC),
      .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
   ) u_tx (
      .clk      (clk),
      .nRst     (nRst),
      .start    (start_q),
      .rs_in    (tx_rs),
      .data_in  (tx_data),
      .done     (tx_done),
      .lcd_en   (bus.lcd_en),
      .lcd_rs   (bus.lcd_rs),
      .lcd_data (bus.lcd_data)
   );

   assign bus.lcd_rw     = 1'b0;
   assign bus.busy       = busy_q;
   assign bus.frame_done = fdone_q;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Randomised scoreboard bench for lcd_frame_writer with shortened timing.
// Latency: expected bytes are queued at stimulus time, popped on each enable rise.
// Backpressure: none; the monitor only observes.
module tb_lcd_frame_writer;
   localparam int P   = 20;
   localparam int S   = 2;
   localparam int E   = 3;
   localparam int W   = 4;
   localparam int CLR = 10;

   logic clk  = 1'b0;
   logic nRst = 1'b0;
   always #5 clk = ~clk;

   lcd_frame_writer_if bus_if ();

   lcd_frame_writer #(
      .POWERUP_CYC    (P),
      .SETUP_CYC      (S),
      .EN_CYC         (E),
      .WAIT_CYC       (W),
      .CLEAR_WAIT_CYC (CLR)
   ) dut (
      .clk  (clk),
      .nRst (nRst),
      .bus  (bus_if)
   );

   typedef struct packed {
      logic       rs;
      logic [7:0] dat;
      logic       chained;   // follows the previous byte with no idle time
   } exp_t;

   exp_t         q[$];
   exp_t         mon_e;
   int           checks = 0;
   int           errors = 0;
   int           fd_count = 0;
   int           exp_frames = 0;
   int           rise_count = 0;
   int           cyc = 0;
   int           rel_cyc = 0;
   int           rise_cyc = 0;
   int           fall_cyc = 0;
   int           last_wait = 0;
   logic         prev_en = 1'b0;
   logic         after_rst = 1'b1;
   logic         chk_busy = 1'b0;
   logic         cap_rs = 1'b0;
   logic [7:0]   cap_dat = 8'h00;
   logic [127:0] m_top, m_bot;

   // Reference rule: anything outside printable ASCII shows as a blank
   function automatic logic [7:0] model_char(input logic [7:0] c);
      if (c < 8'h20 || c > 8'h7E) return 8'h20;
      return c;
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic push_byte(input logic rs, input logic [7:0] d, input logic ch);
      exp_t e;
      e.rs = rs; e.dat = d; e.chained = ch;
      q.push_back(e);
   endtask

   task automatic push_init();
      push_byte(1'b0, 8'h38, 1'b0);
      push_byte(1'b0, 8'h0C, 1'b1);
      push_byte(1'b0, 8'h06, 1'b1);
      push_byte(1'b0, 8'h01, 1'b1);
   endtask

   // A frame: row-0 address, 16 chars MSB-first, row-1 address, 16 chars
   task automatic push_frame(input logic [127:0] t, input logic [127:0] b, input logic ch);
      push_byte(1'b0, 8'h80, ch);
      for (int c = 0; c < 16; c++) push_byte(1'b1, model_char(t[127-8*c -: 8]), 1'b1);
      push_byte(1'b0, 8'hC0, 1'b1);
      for (int c = 0; c < 16; c++) push_byte(1'b1, model_char(b[127-8*c -: 8]), 1'b1);
      exp_frames++;
   endtask

   task automatic drive(input logic [127:0] t, input logic [127:0] b);
      bus_if.top    = t;
      bus_if.bottom = b;
      m_top = t;
      m_bot = b;
   endtask

   task automatic wait_frames(input int target, input string name);
      int n = 0;
      while (fd_count < target && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, fd_count, target);
   endtask

   task automatic wait_qsize(input int lim, input string name);
      int n = 0;
      while (q.size() > lim && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (q.size() > lim) begin
         errors++;
         $display("FAIL %s: queue depth %0d, expected <= %0d (timeout)", name, q.size(), lim);
      end
   endtask

   // Monitor: pops an expected byte on every enable rise and checks pulse timing
   always @(negedge clk) begin
      cyc++;
      if (!nRst) begin
         prev_en   = 1'b0;
         after_rst = 1'b1;
         rel_cyc   = cyc;
         chk_busy  = 1'b0;
      end else begin
         if (bus_if.lcd_en && !prev_en) begin
            rise_count++;
            check("lcd_rw", bus_if.lcd_rw, 0);
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got rs=%0b data=%02h, expected no transfer",
                        bus_if.lcd_rs, bus_if.lcd_data);
            end else begin
               mon_e = q.pop_front();
               check("byte", {bus_if.lcd_rs, bus_if.lcd_data}, {mon_e.rs, mon_e.dat});
               if (after_rst) check_range("powerup_delay", cyc - rel_cyc, P, P + S + 6);
               else if (mon_e.chained)
                  check_range("byte_gap", cyc - fall_cyc, last_wait + S + 1, last_wait + S + 4);
            end
            after_rst = 1'b0;
            rise_cyc  = cyc;
            cap_rs    = bus_if.lcd_rs;
            cap_dat   = bus_if.lcd_data;
            last_wait = (!cap_rs && cap_dat == 8'h01) ? CLR : W;
         end else if (!bus_if.lcd_en && prev_en) begin
            fall_cyc = cyc;
            check("en_width", cyc - rise_cyc, E);
            check("bus_stable", {bus_if.lcd_rs, bus_if.lcd_data}, {cap_rs, cap_dat});
         end
         if (bus_if.frame_done) begin
            fd_count++;
            check("busy_at_done", bus_if.busy, 1);
            chk_busy = 1'b1;
         end else if (chk_busy) begin
            check("busy_after_done", bus_if.busy, 0);
            chk_busy = 1'b0;
         end
         prev_en = bus_if.lcd_en;
      end
   end

   initial begin
      logic [127:0] t, b;
      int n0;
      int n;

      drive('0, '0);
      nRst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_lcd_en", bus_if.lcd_en, 0);
      check("rst_lcd_rs", bus_if.lcd_rs, 0);
      check("rst_lcd_rw", bus_if.lcd_rw, 0);
      check("rst_lcd_data", bus_if.lcd_data, 0);
      check("rst_frame_done", bus_if.frame_done, 0);
      check("rst_busy", bus_if.busy, 1);

      // Init sequence followed by a blank frame from all-zero rows
      push_init();
      push_frame('0, '0, 1'b1);
      nRst = 1'b1;
      wait_frames(exp_frames, "blank_frame");
      repeat (3) @(posedge clk);
      #1;
      check("idle_busy", bus_if.busy, 0);
      check("queue_drained", q.size(), 0);

      // Content frame
      t = {16{8'h20}};
      t[127-8*6 -: 8] = 8'h57;
      t[127-8*7 -: 8] = 8'h69;
      t[127-8*8 -: 8] = 8'h6E;
      b = {16{8'h20}};
      b[127 -: 8]      = 8'h5F;
      b[127-8*2 -: 8]  = 8'h5F;
      b[127-8*4 -: 8]  = 8'h5F;
      drive(t, b);
      push_frame(t, b, 1'b0);
      wait_frames(exp_frames, "content_frame");

      // Unchanged inputs must not trigger a redraw
      n0 = rise_count;
      repeat (1000) @(posedge clk);
      #1;
      check("no_change_pulses", rise_count - n0, 0);
      check("no_change_busy", bus_if.busy, 0);

      // Random rows; first pass uses any byte, last pass forces the sanitise corners
      for (int it = 0; it < 5; it++) begin
         for (int c = 0; c < 16; c++) begin
            t[127-8*c -: 8] = (it == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(32, 126));
            b[127-8*c -: 8] = (it == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(32, 126));
         end
         if (it == 4) begin
            t[127 -: 8] = 8'h07;
            t[7:0]      = 8'h7F;
         end
         if (t == m_top && b == m_bot) t[63:56] = ~t[63:56];
         repeat (2) @(posedge clk);
         #1;
         drive(t, b);
         push_frame(t, b, 1'b0);
         wait_frames(exp_frames, "random_frame");
      end

      // Change column 0 while row 1 is being sent
      t = {16{8'h20}};
      for (int c = 0; c < 16; c++) b[127-8*c -: 8] = 8'($urandom_range(32, 126));
      drive(t, b);
      push_frame(t, b, 1'b0);
      wait_qsize(14, "reach_row1");
      t[127 -: 8] = 8'h41;
      drive(t, m_bot);
      push_frame(t, m_bot, 1'b0);
      wait_frames(exp_frames, "midframe_frames");
      n0 = rise_count;
      repeat (300) @(posedge clk);
      #1;
      check("midframe_no_extra", rise_count - n0, 0);
      check("midframe_queue", q.size(), 0);

      // Reset during the enable pulse of a row-0 byte
      for (int c = 0; c < 16; c++) b[127-8*c -: 8] = 8'($urandom_range(32, 126));
      drive(m_top, b);
      push_frame(m_top, m_bot, 1'b0);
      wait_qsize(29, "reach_row0");
      n = 0;
      while (!bus_if.lcd_en && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("en_high_before_reset", bus_if.lcd_en, 1);
      nRst = 1'b0;
      #1;
      check("async_rst_en", bus_if.lcd_en, 0);
      check("async_rst_busy", bus_if.busy, 1);
      check("async_rst_rs", bus_if.lcd_rs, 0);
      check("async_rst_data", bus_if.lcd_data, 0);
      q.delete();
      exp_frames = fd_count;
      push_init();
      push_frame(m_top, m_bot, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      nRst = 1'b1;
      wait_frames(exp_frames, "frame_after_reset");
      repeat (5) @(posedge clk);
      #1;
      check("total_frames", fd_count, exp_frames);
      check("final_queue", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
